// File: rtl/clk_divider_bank.sv
// Bank of CHANNELS programmable clock dividers. Each channel runs in toggle mode (period 2*D) or pulse mode (period D).
// Divisor and mode writes are shadowed and take effect only at a period boundary, on sync, or while the channel is disabled.
module clk_divider_bank #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 32,
    parameter int DEFAULT_DIV = 12000000,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic                cfg_mode,
    input  logic                cfg_en,
    input  logic                sync,
    output logic [CHANNELS-1:0] out_clk,
    output logic [CHANNELS-1:0] tick,
    output logic                cfg_ack,
    output logic                cfg_err
);
    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    logic cfg_valid;
    assign cfg_valid = (32'(cfg_ch) < 32'(CHANNELS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ack <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_ack <= cfg_wr && cfg_valid;
            cfg_err <= cfg_wr && !cfg_valid;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] div_q;
        logic [CNT_W-1:0] sh_div_q;
        logic [CNT_W-1:0] count_q;
        logic [CNT_W-1:0] div_eff;
        logic [CNT_W-1:0] src_div;
        logic             mode_q;
        logic             sh_mode_q;
        logic             en_q;
        logic             pend_q;
        logic             out_q;
        logic             tick_q;
        logic             hit;
        logic             en_nx;
        logic             src_mode;
        logic             src_pend;
        logic             term;

        // A write in the current cycle is visible as the shadow source immediately,
        // so it can be applied on the same edge when the channel restarts or wraps.
        always_comb begin
            hit      = cfg_wr && cfg_valid && (cfg_ch == CH_W'(i));
            en_nx    = hit ? cfg_en : en_q;
            src_div  = hit ? cfg_div : sh_div_q;
            src_mode = hit ? cfg_mode : sh_mode_q;
            src_pend = hit || pend_q;
            div_eff  = (div_q == '0) ? CNT_W'(1) : div_q;
            term     = (count_q == div_eff - CNT_W'(1));
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                div_q     <= DEF_DIV;
                mode_q    <= 1'b0;
                en_q      <= 1'b1;
                sh_div_q  <= DEF_DIV;
                sh_mode_q <= 1'b0;
                pend_q    <= 1'b0;
                count_q   <= '0;
                out_q     <= 1'b0;
                tick_q    <= 1'b0;
            end else begin
                en_q <= en_nx;
                if (hit) begin
                    sh_div_q  <= cfg_div;
                    sh_mode_q <= cfg_mode;
                end
                if (!en_nx || !en_q || sync) begin
                    // Disabled, just enabled, or synced: park at phase 0 and adopt pending settings now.
                    count_q <= '0;
                    out_q   <= 1'b0;
                    tick_q  <= 1'b0;
                    pend_q  <= 1'b0;
                    if (src_pend) begin
                        div_q  <= src_div;
                        mode_q <= src_mode;
                    end
                end else if (term) begin
                    count_q <= '0;
                    tick_q  <= 1'b1;
                    out_q   <= mode_q ? 1'b1 : ~out_q;
                    pend_q  <= 1'b0;
                    if (src_pend) begin
                        div_q  <= src_div;
                        mode_q <= src_mode;
                    end
                end else begin
                    count_q <= count_q + CNT_W'(1);
                    tick_q  <= 1'b0;
                    pend_q  <= src_pend;
                    if (mode_q) begin
                        out_q <= 1'b0;
                    end
                end
            end
        end

        assign out_clk[i] = out_q;
        assign tick[i]    = tick_q;
    end
endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed, table-driven bench for clk_divider_bank with DEFAULT_DIV shrunk to 8 and a widened cfg_ch.
module tb_clk_divider_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_ch = '0;
    logic [31:0] cfg_div = '0;
    logic        cfg_mode = 1'b0;
    logic        cfg_en = 1'b0;
    logic        sync = 1'b0;
    logic [3:0]  out_clk;
    logic [3:0]  tick;
    logic        cfg_ack;
    logic        cfg_err;

    int passed = 0;
    int total  = 0;

    clk_divider_bank #(
        .CHANNELS   (4),
        .CNT_W      (32),
        .DEFAULT_DIV(8),
        .CH_W       (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg_wr  (cfg_wr),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_mode(cfg_mode),
        .cfg_en  (cfg_en),
        .sync    (sync),
        .out_clk (out_clk),
        .tick    (tick),
        .cfg_ack (cfg_ack),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         skip;
        logic       wr;
        logic [2:0] ch;
        logic [31:0] dv;
        logic       md;
        logic       en;
        logic       sy;
        logic [3:0] mask;
        logic [3:0] o;
        logic [3:0] t;
        logic       ack;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int skip, logic wr, logic [2:0] ch, logic [31:0] dv, logic md,
                                logic en, logic sy, logic [3:0] mask, logic [3:0] o, logic [3:0] t,
                                logic ack, logic err);
        vec_t v;
        v.skip = skip; v.wr = wr; v.ch = ch; v.dv = dv; v.md = md; v.en = en; v.sy = sy;
        v.mask = mask; v.o = o; v.t = t; v.ack = ack; v.err = err;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic drive(logic wr, logic [2:0] ch, logic [31:0] dv, logic md, logic en, logic sy);
        cfg_wr = wr; cfg_ch = ch; cfg_div = dv; cfg_mode = md; cfg_en = en; sync = sy;
    endtask

    initial begin
        // Edge numbers in the notes count posedges after reset release.
        vecs.push_back(mk(1, 1, 0, 4, 0, 1, 0, 4'hF, 4'b0000, 4'b0000, 1, 0)); // e2 ch0 D=4 toggle
        vecs.push_back(mk(5, 0, 0, 0, 0, 0, 0, 4'hF, 4'b1111, 4'b1111, 0, 0)); // e8 default wrap
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'b1111, 4'b0000, 0, 0)); // e9
        vecs.push_back(mk(2, 0, 0, 0, 0, 0, 0, 4'hF, 4'b1110, 4'b0001, 0, 0)); // e12 ch0 new period
        vecs.push_back(mk(3, 0, 0, 0, 0, 0, 0, 4'hF, 4'b0001, 4'b1111, 0, 0)); // e16
        vecs.push_back(mk(0, 1, 1, 3, 1, 1, 0, 4'hF, 4'b0001, 4'b0000, 1, 0)); // e17 ch1 D=3 pulse
        vecs.push_back(mk(0, 1, 2, 1, 0, 1, 0, 4'hF, 4'b0001, 4'b0000, 1, 0)); // e18 ch2 D=1 toggle
        vecs.push_back(mk(0, 1, 3, 0, 1, 1, 0, 4'hF, 4'b0001, 4'b0000, 1, 0)); // e19 ch3 D=0 pulse
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'b0000, 4'b0001, 0, 0)); // e20
        vecs.push_back(mk(3, 0, 0, 0, 0, 0, 0, 4'hF, 4'b1111, 4'b1111, 0, 0)); // e24 shadows applied
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'b1001, 4'b1100, 0, 0)); // e25
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'b1101, 4'b1100, 0, 0)); // e26
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'b1011, 4'b1110, 0, 0)); // e27
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'b1100, 4'b1101, 0, 0)); // e28
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'hF, 4'b1110, 4'b1110, 0, 0)); // e30
        vecs.push_back(mk(3, 1, 0, 5, 0, 0, 0, 4'hF, 4'b1100, 4'b1100, 1, 0)); // e34 disable ch0
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'b1000, 4'b1100, 0, 0)); // e35
        vecs.push_back(mk(0, 1, 0, 5, 0, 1, 0, 4'hF, 4'b1110, 4'b1110, 1, 0)); // e36 re-enable D=5
        vecs.push_back(mk(3, 0, 0, 0, 0, 0, 0, 4'h1, 4'b0000, 4'b0000, 0, 0)); // e40
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h1, 4'b0001, 4'b0001, 0, 0)); // e41 first rise
        vecs.push_back(mk(0, 1, 4, 2, 1, 0, 0, 4'hF, 4'b1111, 4'b1110, 0, 1)); // e42 bad channel
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'b1001, 4'b1100, 0, 0)); // e43
        vecs.push_back(mk(0, 1, 0, 4, 0, 1, 0, 4'hF, 4'b1101, 4'b1100, 1, 0)); // e44 ch0 D=4
        vecs.push_back(mk(1, 1, 1, 6, 0, 1, 0, 4'hF, 4'b1100, 4'b1101, 1, 0)); // e46 ch1 D=6
        vecs.push_back(mk(0, 1, 2, 10, 0, 1, 1, 4'hF, 4'b0000, 4'b0000, 1, 0)); // e47 ch2 D=10 + sync
        vecs.push_back(mk(2, 0, 0, 0, 0, 0, 0, 4'h7, 4'b0000, 4'b0000, 0, 0)); // e50
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'h7, 4'b0001, 4'b0001, 0, 0)); // e51
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4'h7, 4'b0011, 4'b0010, 0, 0)); // e53
        vecs.push_back(mk(3, 0, 0, 0, 0, 0, 0, 4'h7, 4'b0110, 4'b0100, 0, 0)); // e57
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 4'hF, 4'b0000, 4'b0000, 0, 0)); // e59 sync on terminal
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4'hF, 4'b1000, 4'b1000, 0, 0)); // e60
        vecs.push_back(mk(2, 0, 0, 0, 0, 0, 0, 4'h1, 4'b0001, 4'b0001, 0, 0)); // e63

        @(negedge clk);
        check("reset out_clk", 32'(out_clk), 32'h0);
        check("reset tick", 32'(tick), 32'h0);
        check("reset ack/err", 32'({cfg_ack, cfg_err}), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            for (int s = 0; s < vecs[k].skip; s++) begin
                @(posedge clk);
                @(negedge clk);
            end
            drive(vecs[k].wr, vecs[k].ch, vecs[k].dv, vecs[k].md, vecs[k].en, vecs[k].sy);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d out_clk", k), 32'(out_clk & vecs[k].mask), 32'(vecs[k].o & vecs[k].mask));
            check($sformatf("vec%0d tick", k), 32'(tick & vecs[k].mask), 32'(vecs[k].t & vecs[k].mask));
            check($sformatf("vec%0d ack/err", k), 32'({cfg_ack, cfg_err}), 32'({vecs[k].ack, vecs[k].err}));
            drive(0, 0, 0, 0, 0, 0);
        end

        // Reset mid-period, in the cycle a write is being acknowledged, with that write still pending.
        drive(1, 0, 2, 0, 1, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        check("pre-reset ack", 32'(cfg_ack), 32'h1);
        check("pre-reset out0", 32'(out_clk[0]), 32'h1);
        rst = 1'b1;
        #1;
        check("async reset out_clk", 32'(out_clk), 32'h0);
        check("async reset tick", 32'(tick), 32'h0);
        check("async reset ack/err", 32'({cfg_ack, cfg_err}), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("post-reset e%0d out_clk", e), 32'(out_clk),
                  (e >= 8 && e < 16) ? 32'hF : 32'h0);
            check($sformatf("post-reset e%0d tick", e), 32'(tick),
                  (e % 8 == 0) ? 32'hF : 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
